// File: rtl/debounce_multi_pkg.sv
// Shared helpers for the multi-channel debouncer: counter sizing and
// parameter-legality predicates used by the elaboration checks.
package debounce_pkg;

    // Counter width able to hold values 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // A dwell of one cycle would make the filter transparent to single-cycle glitches.
    function automatic bit dwell_legal(int n);
        return n >= 2;
    endfunction

    // Fewer than two flops leaves the raw pin metastability-exposed.
    function automatic bit sync_legal(int n);
        return n >= 2;
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Pin-side bundle of the debouncer: raw inputs in, clean levels and pulses out.
interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] sig_in;
    logic [N_CH-1:0] sig_out;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] held;

    // master: board/stimulus side driving the pins and consuming the pulses
    modport master (
        output sig_in,
        input  sig_out,
        input  rise,
        input  fall,
        input  held
    );

    // slave: the debouncer itself
    modport slave (
        input  sig_in,
        output sig_out,
        output rise,
        output fall,
        output held
    );
endinterface

// File: rtl/debounce_multi_chan.sv
// One debouncer channel: synchroniser, dwell filter, registered edge pulses
// and optional long-press detection.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   DWELL_CNT   = 50000,
    parameter int   SYNC_STAGES = 2,
    parameter int   HOLD_CNT    = 0,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic held_o
);

    localparam int                CNT_W    = cnt_width(DWELL_CNT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CNT - 1);

    if (!dwell_legal(DWELL_CNT)) begin : g_bad_dwell
        $error("debounce_chan: DWELL_CNT must be at least 2");
    end
    if (!sync_legal(SYNC_STAGES)) begin : g_bad_sync
        $error("debounce_chan: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   flip;
    logic                   rise_q, fall_q;

    // Synchroniser chain; the oldest stage is the filtered-domain sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Dwell filter: flip only after DWELL_CNT consecutive disagreeing samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flip    = 1'b0;
        if (s == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = s;
            cnt_d   = '0;
            flip    = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounced level plus rise/fall pulses registered on the edge the level changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= flip & s;
            fall_q  <= flip & ~s;
        end
    end

    assign level_o = state_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

    if (HOLD_CNT > 0) begin : g_hold
        localparam int               HOLD_W    = cnt_width(HOLD_CNT);
        localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);

        logic [HOLD_W-1:0] hcnt_q, hcnt_d;
        logic              armed_q, armed_d;
        logic              held_q, held_d;

        // Long-press: arm on a rise, count while high, fire once, disarm on a fall.
        // The count stops at HOLD_LAST because arming is dropped when it fires.
        always_comb begin
            hcnt_d  = hcnt_q;
            armed_d = armed_q;
            held_d  = 1'b0;
            if (flip) begin
                hcnt_d  = '0;
                armed_d = s;
            end else if (state_q && armed_q) begin
                if (hcnt_q == HOLD_LAST) begin
                    held_d  = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    hcnt_d = hcnt_q + HOLD_W'(1);
                end
            end
        end

        // Hold counter, arm flag and registered long-press pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hcnt_q  <= '0;
                armed_q <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                hcnt_q  <= hcnt_d;
                armed_q <= armed_d;
                held_q  <= held_d;
            end
        end

        assign held_o = held_q;
    end else begin : g_no_hold
        assign held_o = 1'b0;
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: N_CH independent channels between the board
// pins and the game/timing FSMs.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   N_CH        = 4,
    parameter int   DWELL_CNT   = 50000,
    parameter int   SYNC_STAGES = 2,
    parameter int   HOLD_CNT    = 0,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    debounce_multi_if.slave      bus
);

    // One self-contained channel per pin; no state is shared between them.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_chan #(
            .DWELL_CNT   (DWELL_CNT),
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_CNT    (HOLD_CNT),
            .RESET_VAL   (RESET_VAL)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .sig_i   (bus.sig_in[i]),
            .level_o (bus.sig_out[i]),
            .rise_o  (bus.rise[i]),
            .fall_o  (bus.fall[i]),
            .held_o  (bus.held[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: scenario tasks plus randomized traffic, all
// compared against a timestamp/run-length reference model.
module tb_debounce_multi;

    localparam int   N  = 3;
    localparam int   DW = 4;
    localparam int   SY = 2;
    localparam int   HO = 10;
    localparam logic RV = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    debounce_multi_if #(.N_CH(N)) dif ();

    debounce_multi #(
        .N_CH        (N),
        .DWELL_CNT   (DW),
        .SYNC_STAGES (SY),
        .HOLD_CNT    (HO),
        .RESET_VAL   (RV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: input delay line, run length of disagreeing samples,
    // and edge timestamps for the long-press rule.
    logic [N-1:0] m_pipe [SY];
    logic [N-1:0] m_s;
    logic [N-1:0] m_out, m_rise, m_fall, m_held;
    int           m_run [N];
    int           m_lr  [N];
    int           m_lf  [N];
    int           cyc = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int j = 0; j < SY; j++) m_pipe[j] = {N{RV}};
                m_out  = {N{RV}};
                m_rise = '0;
                m_fall = '0;
                m_held = '0;
                for (int c = 0; c < N; c++) begin
                    m_run[c] = 0;
                    m_lr[c]  = -1000000;
                    m_lf[c]  = -1000000;
                end
            end else begin
                cyc = cyc + 1;
                m_s = m_pipe[SY-1];
                for (int j = SY - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
                m_pipe[0] = dif.sig_in;
                m_rise = '0;
                m_fall = '0;
                m_held = '0;
                for (int c = 0; c < N; c++) begin
                    if (m_s[c] != m_out[c]) m_run[c] = m_run[c] + 1;
                    else                    m_run[c] = 0;
                    if (m_run[c] == DW) begin
                        m_run[c] = 0;
                        m_out[c] = m_s[c];
                        if (m_s[c]) begin
                            m_rise[c] = 1'b1;
                            m_lr[c]   = cyc;
                        end else begin
                            m_fall[c] = 1'b1;
                            m_lf[c]   = cyc;
                        end
                    end
                    if (m_out[c] && (cyc - m_lr[c] == HO) && (m_lf[c] < m_lr[c]))
                        m_held[c] = 1'b1;
                end
            end
        end
    end

    wire [4*N-1:0] dut_vec = {dif.sig_out, dif.rise, dif.fall, dif.held};
    wire [4*N-1:0] mdl_vec = {m_out, m_rise, m_fall, m_held};

    task automatic test_reset();
        int rise_at = -1;
        rst_n = 1'b0;
        dif.sig_in = '1;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got %b want %b", dut_vec, {4*N{1'b0}});
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL reset_model e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
            if (e == 1) begin
                n_tests++;
                if ({dif.sig_out, dif.rise} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_release_pulse: got %b want 0", {dif.sig_out, dif.rise});
                end
            end
            if (dif.rise == 3'b111 && rise_at < 0) rise_at = e;
        end
        n_tests++;
        if (rise_at != 6) begin
            n_fail++;
            $display("FAIL reset_rise_edge: got %0d want 6", rise_at);
        end
        n_tests++;
        if (dif.sig_out !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_level: got %b want 111", dif.sig_out);
        end
    endtask

    task automatic test_clean_step();
        int rise_at = -1;
        dif.sig_in = '0;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL step_settle e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
        end
        dif.sig_in[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL step_model e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
            if (dif.rise[0] && rise_at < 0) rise_at = e;
            if (e == 6) begin
                n_tests++;
                if ({dif.sig_out, dif.rise} !== 6'b001_001) begin
                    n_fail++;
                    $display("FAIL step_edge6: got %b want 001001", {dif.sig_out, dif.rise});
                end
            end
            if (e == 7) begin
                n_tests++;
                if (dif.rise !== 3'b000) begin
                    n_fail++;
                    $display("FAIL step_edge7_rise: got %b want 000", dif.rise);
                end
            end
        end
        n_tests++;
        if (rise_at != 6) begin
            n_fail++;
            $display("FAIL step_rise_edge: got %0d want 6", rise_at);
        end
    endtask

    task automatic test_glitch();
        int rises = 0;
        dif.sig_in[1] = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL glitch_model e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
            n_tests++;
            if (dif.sig_out[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_level e=%0d: got %b want 0", e, dif.sig_out[1]);
            end
            if (dif.rise[1]) rises++;
            if (e == 3) dif.sig_in[1] = 1'b0;
        end
        n_tests++;
        if (rises != 0) begin
            n_fail++;
            $display("FAIL glitch_rises: got %0d want 0", rises);
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat = 6'b101101;
        int rises = 0;
        int rise_at = -1;
        dif.sig_in[2] = pat[0];
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL bounce_model e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
            if (dif.rise[2]) begin
                rises++;
                rise_at = e;
            end
            dif.sig_in[2] = (e < 6) ? pat[e] : 1'b1;
        end
        n_tests++;
        if (rises != 1 || rise_at != 11) begin
            n_fail++;
            $display("FAIL bounce_rise: got count %0d at %0d want count 1 at 11", rises, rise_at);
        end
    endtask

    task automatic test_long_press();
        int rise_at = -1;
        int held_at = -1;
        int helds = 0;
        int falls = 0;
        dif.sig_in = '0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL press_settle e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
        end
        dif.sig_in[0] = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL press1_model e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
            if (dif.rise[0] && rise_at < 0) rise_at = e;
            if (dif.held[0]) begin
                helds++;
                held_at = e;
            end
            if (e == 30) dif.sig_in[0] = 1'b0;
        end
        n_tests++;
        if (helds != 1 || held_at - rise_at != HO) begin
            n_fail++;
            $display("FAIL press1_held: got count %0d delay %0d want count 1 delay %0d",
                     helds, held_at - rise_at, HO);
        end
        helds = 0;
        dif.sig_in[0] = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL press2_model e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
            if (dif.held[0]) helds++;
            if (dif.fall[0]) falls++;
            if (e == 8) dif.sig_in[0] = 1'b0;
        end
        n_tests++;
        if (helds != 0 || falls != 1) begin
            n_fail++;
            $display("FAIL press2_short: got held %0d fall %0d want held 0 fall 1", helds, falls);
        end
    endtask

    task automatic test_reset_mid();
        dif.sig_in = '0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL mid_settle e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
        end
        dif.sig_in = 3'b001;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL mid_pre e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL mid_in_reset: got %b want 0", dut_vec);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL mid_post e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            end
            if (e == 5) begin
                n_tests++;
                if (dif.sig_out[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_early: got %b want 0", dif.sig_out[0]);
                end
            end
            if (e == 6) begin
                n_tests++;
                if ({dif.sig_out[0], dif.rise[0]} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL mid_edge6: got %b want 11", {dif.sig_out[0], dif.rise[0]});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 8; blk++) begin
            for (int e = 0; e < 60; e++) begin
                for (int c = 0; c < N; c++) begin
                    if (blk % 2 == 0) begin
                        if ($urandom_range(0, 3) == 0) dif.sig_in[c] = ~dif.sig_in[c];
                    end else begin
                        if ($urandom_range(0, 39) == 0) dif.sig_in[c] = ~dif.sig_in[c];
                    end
                end
                @(negedge clk);
                n_tests++;
                if (dut_vec !== mdl_vec) begin
                    n_fail++;
                    $display("FAIL random blk=%0d e=%0d: got %b want %b", blk, e, dut_vec, mdl_vec);
                end
            end
        end
    endtask

    initial begin
        dif.sig_in = '0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_long_press();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
